// File: rtl/character_jump_ctrl_pkg.sv
// Shared definitions for the character jump controller: playfield and
// character geometry, VGA bus width and the motion FSM state encoding.
package character_jump_ctrl_pkg;

  localparam int GAME_WIDTH   = 800;
  localparam int GAME_HEIGHT  = 600;
  localparam int CHAR_W       = 40;
  localparam int CHAR_H       = 60;
  localparam int VGA_BUS_SIZE = 38;

  // Encoding 2'b11 is illegal and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_JUMP_L = 2'b01,
    S_JUMP_R = 2'b10
  } state_e;

endpackage

// File: rtl/character_jump_ctrl_jump_arc.sv
// Combinational jump arc: maps elapsed tick count t to the vertical lift
// above ground, (t * (N - t)) >> ARC_SHIFT, a parabola that is zero at both
// ends of the jump and peaks halfway through.
module character_jump_ctrl_jump_arc #(
  parameter int JUMP_TICKS = 80,
  parameter int ARC_SHIFT  = 4,
  parameter int COORD_W    = 10,
  localparam int TW        = $clog2(JUMP_TICKS + 1)
) (
  input  logic [TW-1:0]      t,
  output logic [COORD_W-1:0] offset
);

  logic [TW-1:0]   t_rem;
  logic [2*TW-1:0] prod;

  assign t_rem  = TW'(JUMP_TICKS) - t;
  assign prod   = {{TW{1'b0}}, t} * {{TW{1'b0}}, t_rem};
  assign offset = COORD_W'(prod >> ARC_SHIFT);

endmodule

// File: rtl/character_jump_ctrl.sv
// Character jump controller: turns left/right jump requests into N-tick
// jumps with a parabolic vertical arc and horizontal motion clamped to
// [X_MIN, X_MAX]. Pulses landed for one clock when a jump ends.
// Optional build macro JUMP_QUEUE_EN adds a one-deep queue that captures
// the first request edge seen mid-jump and launches it on landing.
module character_jump_ctrl
  import character_jump_ctrl_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int START_X    = GAME_WIDTH / 2 - CHAR_W / 2 - 1,
  parameter int GROUND_Y   = 450,
  parameter int JUMP_TICKS = 80,
  parameter int STEP_X     = 1,
  parameter int ARC_SHIFT  = 4,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = GAME_WIDTH - CHAR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               module_en,
  input  logic               jump_left,
  input  logic               jump_right,
  input  logic               one_ms_tick,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               landed,
  output logic               busy,
  output logic               dir
);

  localparam int TW = $clog2(JUMP_TICKS + 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic               landed_q, landed_d;
  logic               busy_q, busy_d;
  logic               dir_q, dir_d;

  logic [TW-1:0]      t_nxt;
  logic               last_tick;
  logic [COORD_W-1:0] arc_off;

  // Step right, saturating at X_MAX; sum carries one extra bit so it cannot wrap.
  function automatic logic [COORD_W-1:0] sat_right(input logic [COORD_W-1:0] x);
    logic [COORD_W:0] sum;
    sum = {1'b0, x} + (COORD_W+1)'(STEP_X);
    if (sum > (COORD_W+1)'(X_MAX)) return COORD_W'(X_MAX);
    return sum[COORD_W-1:0];
  endfunction

  // Step left, saturating at X_MIN; compared before subtracting so it cannot wrap.
  function automatic logic [COORD_W-1:0] sat_left(input logic [COORD_W-1:0] x);
    if ({1'b0, x} < (COORD_W+1)'(X_MIN) + (COORD_W+1)'(STEP_X)) return COORD_W'(X_MIN);
    return x - COORD_W'(STEP_X);
  endfunction

  assign t_nxt     = t_q + TW'(1);
  assign last_tick = (t_q == TW'(JUMP_TICKS - 1));

  character_jump_ctrl_jump_arc #(
    .JUMP_TICKS (JUMP_TICKS),
    .ARC_SHIFT  (ARC_SHIFT),
    .COORD_W    (COORD_W)
  ) u_arc (
    .t      (t_nxt),
    .offset (arc_off)
  );

`ifdef JUMP_QUEUE_EN
  logic q_valid_q, q_valid_d;
  logic q_dir_q, q_dir_d;
  logic req_l_prev_q, req_r_prev_q;
  logic edge_l, edge_r;

  assign edge_l = jump_left  & ~req_l_prev_q;
  assign edge_r = jump_right & ~req_r_prev_q;
`endif

  // Next-state, position and status logic for the motion FSM.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    landed_d = 1'b0;
    busy_d   = busy_q;
    dir_d    = dir_q;
`ifdef JUMP_QUEUE_EN
    q_valid_d = q_valid_q;
    q_dir_d   = q_dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (jump_left) begin
          state_d = S_JUMP_L;
          t_d     = '0;
          busy_d  = 1'b1;
          dir_d   = 1'b0;
        end else if (jump_right) begin
          state_d = S_JUMP_R;
          t_d     = '0;
          busy_d  = 1'b1;
          dir_d   = 1'b1;
        end else if (!module_en) begin
          xpos_d = COORD_W'(START_X);
          ypos_d = COORD_W'(GROUND_Y);
        end
      end
      S_JUMP_L, S_JUMP_R: begin
`ifdef JUMP_QUEUE_EN
        if (!q_valid_q && (edge_l || edge_r) && !(one_ms_tick && last_tick)) begin
          q_valid_d = 1'b1;
          q_dir_d   = ~edge_l;
        end
`endif
        if (one_ms_tick) begin
          t_d    = t_nxt;
          xpos_d = (state_q == S_JUMP_R) ? sat_right(xpos_q) : sat_left(xpos_q);
          ypos_d = COORD_W'(GROUND_Y) - arc_off;
          if (last_tick) begin
            t_d      = '0;
            ypos_d   = COORD_W'(GROUND_Y);
            landed_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
`ifdef JUMP_QUEUE_EN
            if (q_valid_q && module_en) begin
              state_d = q_dir_q ? S_JUMP_R : S_JUMP_L;
              busy_d  = 1'b1;
              dir_d   = q_dir_q;
            end
            q_valid_d = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
`ifdef JUMP_QUEUE_EN
    if (!module_en) q_valid_d = 1'b0;
`endif
  end

  // Motion state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      xpos_q   <= COORD_W'(START_X);
      ypos_q   <= COORD_W'(GROUND_Y);
      landed_q <= 1'b0;
      busy_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      landed_q <= landed_d;
      busy_q   <= busy_d;
      dir_q    <= dir_d;
    end
  end

`ifdef JUMP_QUEUE_EN
  // Queue slot and request history used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid_q    <= 1'b0;
      q_dir_q      <= 1'b0;
      req_l_prev_q <= 1'b0;
      req_r_prev_q <= 1'b0;
    end else begin
      q_valid_q    <= q_valid_d;
      q_dir_q      <= q_dir_d;
      req_l_prev_q <= jump_left;
      req_r_prev_q <= jump_right;
    end
  end
`endif

  assign xpos   = xpos_q;
  assign ypos   = ypos_q;
  assign landed = landed_q;
  assign busy   = busy_q;
  assign dir    = dir_q;

endmodule

// File: tb/tb_character_jump_ctrl.sv
// Self-checking bench for character_jump_ctrl: directed scenarios with
// literal expectations followed by randomized traffic, all compared each
// cycle against a behavioural model of the jump rules.
module tb_character_jump_ctrl;

  localparam int N      = 80;
  localparam int START  = 379;
  localparam int GROUND = 450;
  localparam int XMIN   = 0;
  localparam int XMAX   = 760;
  localparam int STEP   = 1;
  localparam int SHIFT  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       module_en = 1'b0;
  logic       jump_left = 1'b0;
  logic       jump_right = 1'b0;
  logic       one_ms_tick = 1'b0;
  logic [9:0] xpos, ypos;
  logic       landed, busy, dir;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  character_jump_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .one_ms_tick (one_ms_tick),
    .xpos        (xpos),
    .ypos        (ypos),
    .landed      (landed),
    .busy        (busy),
    .dir         (dir)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a jump is "in the air" for N ticks; position after k
  // ticks follows directly from the rules (clamped step, parabola).
  int mx, my, mt;
  bit in_air, mdir, mbusy, mland;
`ifdef JUMP_QUEUE_EN
  bit mqv, mqd, mpl, mpr, el, er;
`endif

  always @(posedge clk) begin
    if (rst) begin
      mx = START; my = GROUND; mt = 0; in_air = 0; mdir = 0; mbusy = 0; mland = 0;
`ifdef JUMP_QUEUE_EN
      mqv = 0; mqd = 0; mpl = 0; mpr = 0;
`endif
    end else begin
      bit landing;
      landing = 0;
      mland = 0;
`ifdef JUMP_QUEUE_EN
      el = jump_left && !mpl;
      er = jump_right && !mpr;
`endif
      if (!in_air) begin
        if (jump_left || jump_right) begin
          in_air = 1; mdir = !jump_left; mt = 0; mbusy = 1;
        end else if (!module_en) begin
          mx = START; my = GROUND;
        end
      end else begin
        if (one_ms_tick) begin
          mt = mt + 1;
          if (mdir) mx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
          else      mx = (mx - STEP < XMIN) ? XMIN : mx - STEP;
          if (mt == N) begin
            landing = 1; mland = 1; my = GROUND; mt = 0; in_air = 0; mbusy = 0;
`ifdef JUMP_QUEUE_EN
            if (mqv && module_en) begin in_air = 1; mbusy = 1; mdir = mqd; end
`endif
          end else begin
            my = GROUND - ((mt * (N - mt)) >> SHIFT);
          end
        end
`ifdef JUMP_QUEUE_EN
        if (!landing && !mqv && (el || er)) begin mqv = 1; mqd = !el; end
`endif
      end
`ifdef JUMP_QUEUE_EN
      if (landing || !module_en) mqv = 0;
      mpl = jump_left; mpr = jump_right;
`else
      if (landing) mt = 0;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("xpos", 32'(xpos), 32'(mx));
      check("ypos", 32'(ypos), 32'(my));
      check("landed", 32'(landed), 32'(mland));
      check("busy", 32'(busy), 32'(mbusy));
      check("dir", 32'(dir), 32'(mdir));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    one_ms_tick = 1'b1;
    step();
    one_ms_tick = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  // n ticks with random spacing; returns right after the n-th tick edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) gap();
      tick();
    end
  endtask

  task automatic request(input bit l, input bit r);
    jump_left = l; jump_right = r;
    step();
    jump_left = 1'b0; jump_right = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step(); step();
    check("rst_xpos", 32'(xpos), 379);
    check("rst_ypos", 32'(ypos), 450);
    check("rst_landed", 32'(landed), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dir", 32'(dir), 0);
    rst = 1'b0;
    step(); step();
    check("idle_dis_xpos", 32'(xpos), 379);

    // Right jump: peak after tick 40, land after tick 80.
    module_en = 1'b1;
    request(1'b0, 1'b1);
    check("jr_busy", 32'(busy), 1);
    check("jr_dir", 32'(dir), 1);
    ticks(40);
    check("peak_ypos", 32'(ypos), 350);
    check("model_peak", 32'(my), 350);
    check("peak_xpos", 32'(xpos), 419);
    gap();
    ticks(40);
    check("land_pulse", 32'(landed), 1);
    check("land_xpos", 32'(xpos), 459);
    check("model_land_x", 32'(mx), 459);
    check("land_ypos", 32'(ypos), 450);
    check("land_busy", 32'(busy), 0);
    step();
    check("land_single", 32'(landed), 0);

    // Both requests: left wins.
    request(1'b1, 1'b1);
    check("both_dir", 32'(dir), 0);
    check("both_busy", 32'(busy), 1);
    ticks(N);
    check("both_xpos", 32'(xpos), 379);

    // Reset during a jump.
    request(1'b0, 1'b1);
    ticks(30);
    check("mid_xpos", 32'(xpos), 409);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_xpos", 32'(xpos), 379);
    check("rstmid_ypos", 32'(ypos), 450);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_landed", 32'(landed), 0);
    step();
    check("rstmid_nolanded", 32'(landed), 0);

    // Right saturation at X_MAX, then left saturation at X_MIN.
    for (int k = 0; k < 5; k++) begin request(1'b0, 1'b1); ticks(N); step(); end
    check("sat_right", 32'(xpos), 760);
    for (int k = 0; k < 10; k++) begin request(1'b1, 1'b0); ticks(N); step(); end
    check("sat_left", 32'(xpos), 0);
    module_en = 1'b0;
    step();
    check("dis_force_x", 32'(xpos), 379);
    module_en = 1'b1;

    // module_en falling mid-jump lets the jump finish, then forces idle.
    request(1'b0, 1'b1);
    ticks(10);
    module_en = 1'b0;
    ticks(N - 10);
    check("en_fall_land", 32'(landed), 1);
    check("en_fall_x", 32'(xpos), 459);
    step();
    check("en_fall_force", 32'(xpos), 379);
    module_en = 1'b1;

`ifdef JUMP_QUEUE_EN
    request(1'b0, 1'b1);
    ticks(20);
    request(1'b1, 1'b0);
    ticks(N - 20);
    check("q_landed", 32'(landed), 1);
    check("q_busy", 32'(busy), 1);
    check("q_dir", 32'(dir), 0);
    ticks(N);
    check("q_xpos", 32'(xpos), 379);
    step();
`endif

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) module_en = ~module_en;
      jump_left   = ($urandom_range(0, 9) == 0);
      jump_right  = ($urandom_range(0, 9) == 0);
      one_ms_tick = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; jump_left = 1'b0; jump_right = 1'b0; one_ms_tick = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
